// File: rtl/puneh_mem_responder_if.sv
// Loader handshake bundle for the PUNEH memory responder: a byte-serial
// valid/ready stream plus the start/done/word-count control around it.
interface puneh_mem_responder_if #(
    parameter int ADDR_WIDTH = 12
) ();
    logic                  ld_start;
    logic                  ld_valid;
    logic [7:0]            ld_byte;
    logic                  ld_last;
    logic                  ld_ready;
    logic                  ld_done;
    logic [ADDR_WIDTH:0]   ld_words;

    modport master (
        output ld_start, ld_valid, ld_byte, ld_last,
        input  ld_ready, ld_done, ld_words
    );

    modport slave (
        input  ld_start, ld_valid, ld_byte, ld_last,
        output ld_ready, ld_done, ld_words
    );
endinterface

// File: rtl/puneh_mem_responder.sv
// Memory-side responder for the PUNEH bus: tristate reads, clocked writes and a
// byte-serial program loader that holds the CPU off. Optional bus_err via PUNEH_MEM_CHECK_EN.
module puneh_mem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LOAD_BASE  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           addrBus,
    inout  wire  [15:0]           dataBus,
    input  logic                  readMEM,
    input  logic                  writeMEM,
    output logic                  cpu_hold,
    puneh_mem_responder_if.slave  ld
`ifdef PUNEH_MEM_CHECK_EN
    ,
    output logic                  bus_err
`endif
);

    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] BASE_PTR  = ADDR_WIDTH'(LOAD_BASE);
    localparam logic [ADDR_WIDTH:0]   WORDS_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, LO, HI, FIN} state_t;

    state_t                  state;
    state_t                  nextState;
    logic [15:0]             mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [ADDR_WIDTH-1:0]   cpuAddr;
    logic [7:0]              lowByte;
    logic [ADDR_WIDTH:0]     words;
    logic                    ldReady;
    logic                    ldDone;
    logic                    ldWrite;
    logic                    startLoad;
    logic [15:0]             ldWord;
    logic                    cpuRead;
    logic                    cpuWrite;

    assign cpuAddr = addrBus[ADDR_WIDTH-1:0];

    generate
        if (ADDR_WIDTH < 16) begin : g_alias
            logic unusedAddrBits;
            assign unusedAddrBits = ^addrBus[15:ADDR_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        cpu_hold  = 1'b0;
        ldReady   = 1'b0;
        ldDone    = 1'b0;
        ldWrite   = 1'b0;
        startLoad = 1'b0;
        ldWord    = {ld.ld_byte, lowByte};
        case (state)
            IDLE: begin
                if (ld.ld_start) begin
                    nextState = LO;
                    startLoad = 1'b1;
                end
            end
            LO: begin
                cpu_hold = 1'b1;
                ldReady  = 1'b1;
                if (ld.ld_valid) begin
                    if (ld.ld_last) begin
                        // An odd-length image ends on a lone low byte
                        ldWrite   = 1'b1;
                        ldWord    = {8'h00, ld.ld_byte};
                        nextState = FIN;
                    end else begin
                        nextState = HI;
                    end
                end
            end
            HI: begin
                cpu_hold = 1'b1;
                ldReady  = 1'b1;
                if (ld.ld_valid) begin
                    ldWrite   = 1'b1;
                    nextState = ld.ld_last ? FIN : LO;
                end
            end
            FIN: begin
                cpu_hold  = 1'b1;
                ldDone    = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    assign ld.ld_ready = ldReady;
    assign ld.ld_done  = ldDone;
    assign ld.ld_words = words;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= BASE_PTR;
            lowByte <= 8'h00;
            words   <= '0;
        end else begin
            if (startLoad) begin
                ptr   <= BASE_PTR;
                words <= '0;
            end
            if (state == LO && ld.ld_valid) lowByte <= ld.ld_byte;
            if (ldWrite) begin
                ptr <= ptr + ADDR_WIDTH'(1);
                if (words != WORDS_MAX) words <= words + (ADDR_WIDTH + 1)'(1);
            end
        end
    end

    // The loader and the CPU never write together: the CPU is held whenever the loader writes
    assign cpuRead  = readMEM && !writeMEM && !cpu_hold;
    assign cpuWrite = writeMEM && !cpu_hold;

    always_ff @(posedge clk) begin
        if (ldWrite)       mem[ptr]     <= ldWord;
        else if (cpuWrite) mem[cpuAddr] <= dataBus;
    end

    assign dataBus = cpuRead ? mem[cpuAddr] : 16'hzzzz;

`ifdef PUNEH_MEM_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_err <= 1'b0;
        end else if ((readMEM && writeMEM && !cpu_hold) ||
                     ((readMEM || writeMEM) && cpu_hold) ||
                     (ld.ld_valid && (state == IDLE || state == FIN))) begin
            bus_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_puneh_mem_responder.sv
// Self-checking bench for puneh_mem_responder: directed bus/loader cases plus
// randomized loads and CPU traffic checked against an array-based memory model.
module tb_puneh_mem_responder;

    localparam int ADDR_WIDTH = 12;
    localparam int LOAD_BASE  = 0;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addrBus;
    logic        readMEM;
    logic        writeMEM;
    logic        cpu_hold;
    logic        tbDrive;
    logic [15:0] tbData;
    wire  [15:0] dataBus;
`ifdef PUNEH_MEM_CHECK_EN
    logic        bus_err;
`endif

    int total = 0;
    int bad = 0;
    int doneCount = 0;

    logic [15:0] refMem [DEPTH];
    logic [15:0] writtenAddrs[$];

    puneh_mem_responder_if #(.ADDR_WIDTH(ADDR_WIDTH)) ldIf ();

    puneh_mem_responder #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .LOAD_BASE (LOAD_BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addrBus  (addrBus),
        .dataBus  (dataBus),
        .readMEM  (readMEM),
        .writeMEM (writeMEM),
        .cpu_hold (cpu_hold),
        .ld       (ldIf.slave)
`ifdef PUNEH_MEM_CHECK_EN
        ,
        .bus_err  (bus_err)
`endif
    );

    assign dataBus = tbDrive ? tbData : 16'hzzzz;

    always #5 clk = ~clk;

    always @(negedge clk) if (ldIf.ld_done === 1'b1) doneCount++;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference loader: pack bytes little-endian into words from LOAD_BASE, wrap the address, saturate the count
    function automatic int modelLoad(input logic [7:0] b[$]);
        int n = b.size();
        int w = 0;
        logic [15:0] word;
        for (int i = 0; i < n; i += 2) begin
            word = (i + 1 < n) ? {b[i+1], b[i]} : {8'h00, b[i]};
            refMem[(LOAD_BASE + w) % DEPTH] = word;
            w++;
        end
        return (w > DEPTH) ? DEPTH : w;
    endfunction

    task automatic cpuWrite(input logic [15:0] addr, input logic [15:0] data, input bit both);
        @(negedge clk);
        addrBus  = addr;
        tbData   = data;
        tbDrive  = 1'b1;
        writeMEM = 1'b1;
        readMEM  = both;
        @(negedge clk);
        writeMEM = 1'b0;
        readMEM  = 1'b0;
        tbDrive  = 1'b0;
        refMem[addr[ADDR_WIDTH-1:0]] = data;
        writtenAddrs.push_back(addr);
    endtask

    task automatic cpuRead(input string tag, input logic [15:0] addr);
        @(negedge clk);
        addrBus = addr;
        readMEM = 1'b1;
        #1;
        checkOutput(tag, dataBus, refMem[addr[ADDR_WIDTH-1:0]]);
        @(negedge clk);
        readMEM = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] bytes[$], input int maxGap, input bit intrude);
        int startDone;
        int waitCyc;
        int expWords;
        bit aborted = 1'b0;
        logic [15:0] probe;
        startDone = doneCount;
        @(negedge clk);
        ldIf.ld_start = 1'b1;
        @(negedge clk);
        ldIf.ld_start = 1'b0;
        checkOutput("hold_after_start", {15'd0, cpu_hold}, 16'd1);
        if (intrude) begin
            probe    = refMem[16];
            addrBus  = 16'h0010;
            tbData   = 16'hFFFF;
            tbDrive  = 1'b1;
            writeMEM = 1'b1;
            @(negedge clk);
            writeMEM = 1'b0;
            tbDrive  = 1'b0;
            readMEM  = 1'b1;
            #1;
            checkOutput("hold_no_drive", {15'd0, dataBus !== probe}, 16'd1);
            @(negedge clk);
            readMEM = 1'b0;
        end
        for (int i = 0; i < bytes.size() && !aborted; i++) begin
            repeat ($urandom_range(0, maxGap)) @(negedge clk);
            ldIf.ld_valid = 1'b1;
            ldIf.ld_byte  = bytes[i];
            ldIf.ld_last  = (i == bytes.size() - 1);
            ldIf.ld_start = 1'($urandom_range(0, 1));
            waitCyc = 0;
            while (ldIf.ld_ready !== 1'b1 && waitCyc < 20) begin
                @(negedge clk);
                waitCyc++;
            end
            if (waitCyc == 20) begin
                checkOutput("ld_ready_timeout", 16'd0, 16'd1);
                aborted = 1'b1;
            end
            @(negedge clk);
            ldIf.ld_valid = 1'b0;
            ldIf.ld_last  = 1'b0;
            ldIf.ld_start = 1'b0;
        end
        expWords = modelLoad(bytes);
        checkOutput("fin_done", {15'd0, ldIf.ld_done}, 16'd1);
        checkOutput("fin_hold", {15'd0, cpu_hold}, 16'd1);
        checkOutput("fin_ready", {15'd0, ldIf.ld_ready}, 16'd0);
        @(negedge clk);
        checkOutput("idle_hold", {15'd0, cpu_hold}, 16'd0);
        checkOutput("idle_done", {15'd0, ldIf.ld_done}, 16'd0);
        checkOutput("ld_words", 16'(ldIf.ld_words), 16'(expWords));
        checkOutput("done_pulses", 16'(doneCount - startDone), 16'd1);
    endtask

    initial begin
        logic [7:0] img[$];
        logic [15:0] a;
        int nw;
        rst = 1'b1;
        addrBus = '0; readMEM = 1'b0; writeMEM = 1'b0; tbDrive = 1'b0; tbData = '0;
        ldIf.ld_start = 1'b0; ldIf.ld_valid = 1'b0; ldIf.ld_byte = '0; ldIf.ld_last = 1'b0;
        #23;
        checkOutput("rst_hold", {15'd0, cpu_hold}, 16'd0);
        checkOutput("rst_ready", {15'd0, ldIf.ld_ready}, 16'd0);
        checkOutput("rst_done", {15'd0, ldIf.ld_done}, 16'd0);
        checkOutput("rst_words", 16'(ldIf.ld_words), 16'd0);
`ifdef PUNEH_MEM_CHECK_EN
        checkOutput("rst_bus_err", {15'd0, bus_err}, 16'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] CPU write/read and aliasing");
        cpuWrite(16'h0005, 16'hBEEF, 1'b0);
        cpuRead("read_beef", 16'h0005);
        @(negedge clk);
        addrBus = 16'h0005;
        #1;
        checkOutput("bus_idle", {15'd0, dataBus !== 16'hBEEF}, 16'd1);
        cpuWrite(16'h1003, 16'h1234, 1'b0);
        cpuRead("alias_read", 16'h0003);
        cpuWrite(16'h0010, 16'h0A0A, 1'b0);

        $display("[TB] Load with stalls and hold isolation");
        img = '{8'h34, 8'h12, 8'h78, 8'h56};
        applyStimulus(img, 2, 1'b1);
        cpuRead("load_w0", 16'h0000);
        cpuRead("load_w1", 16'h0001);
        cpuRead("hold_mem_kept", 16'h0010);
`ifdef PUNEH_MEM_CHECK_EN
        checkOutput("bus_err_set", {15'd0, bus_err}, 16'd1);
`endif

        $display("[TB] Odd image");
        img = '{8'hAA, 8'hBB, 8'hCC};
        applyStimulus(img, 1, 1'b0);
        cpuRead("odd_w0", 16'h0000);
        cpuRead("odd_w1", 16'h0001);

        cpuWrite(16'h0020, 16'h5A5A, 1'b1);
        cpuRead("both_strobe_write", 16'h0020);

        $display("[TB] Reset mid-load");
        @(negedge clk);
        ldIf.ld_start = 1'b1;
        @(negedge clk);
        ldIf.ld_start = 1'b0;
        img = '{8'h11, 8'h22, 8'h33};
        foreach (img[i]) begin
            ldIf.ld_valid = 1'b1;
            ldIf.ld_byte  = img[i];
            @(negedge clk);
        end
        ldIf.ld_valid = 1'b0;
        refMem[LOAD_BASE % DEPTH] = 16'h2211;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_hold", {15'd0, cpu_hold}, 16'd0);
        checkOutput("rst_mid_ready", {15'd0, ldIf.ld_ready}, 16'd0);
        checkOutput("rst_mid_words", 16'(ldIf.ld_words), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ready", {15'd0, ldIf.ld_ready}, 16'd0);
        cpuRead("rst_mid_w0", 16'h0000);

        $display("[TB] Randomized loads and CPU traffic");
        for (int t = 0; t < 6; t++) begin
            img.delete();
            repeat ($urandom_range(1, 9)) img.push_back(8'($urandom));
            applyStimulus(img, 2, 1'b0);
            nw = (img.size() + 1) / 2;
            for (int w = 0; w < nw; w++) cpuRead("rand_load_word", 16'(LOAD_BASE + w));
            repeat (4) begin
                a = 16'($urandom);
                cpuWrite(a, 16'($urandom), 1'b0);
            end
            repeat (4) begin
                a = writtenAddrs[$urandom_range(0, writtenAddrs.size() - 1)];
                cpuRead("rand_cpu_read", a);
            end
        end

        $display("[TB] Wrap and saturation");
        img.delete();
        repeat (2 * DEPTH + 2) img.push_back(8'($urandom));
        applyStimulus(img, 0, 1'b0);
        cpuRead("wrap_w0", 16'h0000);
        cpuRead("wrap_w1", 16'h0001);
        cpuRead("wrap_top", 16'(DEPTH - 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
